// File: rtl/mch3d_pkg.sv
// Shared constants and state encoding for the SPI command receiver.
package mch3d_pkg;

    localparam int CMD_BYTE_W   = 8;
    localparam int SPI_BITCNT_W = 3;

    typedef enum logic {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_command_receiver_sync_bit.sv
// N-stage single-bit synchronizer with selectable reset level.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_command_receiver.sv
// SPI mode-0 slave that oversamples the SPI pins in the clk domain and
// pushes each completed byte into command_fifo as a one-cycle strobe.
// Optional interrupt output enabled by defining SPI_IRQ_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SPI_IDLE  | CS deasserted; bit counter held at 0, sclk edges ignored
// SPI_SHIFT | CS asserted; each sclk rise shifts one MOSI bit in
module spi_command_receiver
    import mch3d_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    input  logic                  command_full,
    output logic [CMD_BYTE_W-1:0] command_wrdata,
    output logic                  command_push,
    output logic                  frame_active,
    output logic                  overflow,
    output logic                  irq_n
);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_h_q, cs_h_q, mosi_h_q;

    spi_state_e              state_q, state_d;
    logic [SPI_BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CMD_BYTE_W-1:0]   shreg_q, shreg_d;
    logic [CMD_BYTE_W-1:0]   wrdata_q, wrdata_d;
    logic                    push_q, push_d;
    logic                    ovf_q, ovf_d;

    logic                    sclk_rise, cs_fall;
    logic [CMD_BYTE_W-1:0]   shift_val;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(spi_clk),  .q_o(sclk_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n), .q_o(cs_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(spi_mosi), .q_o(mosi_s)
    );

    // History flops, one per input, so all three paths see equal delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_h_q <= 1'b0;
            cs_h_q   <= 1'b1;
            mosi_h_q <= 1'b0;
        end else begin
            sclk_h_q <= sclk_s;
            cs_h_q   <= cs_s;
            mosi_h_q <= mosi_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_h_q;
    assign cs_fall   = cs_h_q & ~cs_s;

    // MOSI is taken from the history stage: the level held just before the
    // sclk rise, which is the mode-0 sampling point.
    assign shift_val = MSB_FIRST ? {shreg_q[CMD_BYTE_W-2:0], mosi_h_q}
                                 : {mosi_h_q, shreg_q[CMD_BYTE_W-1:1]};

    // State, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SPI_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            wrdata_q  <= '0;
            push_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            wrdata_q  <= wrdata_d;
            push_q    <= push_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic: bit assembly, push generation and overflow tracking.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        wrdata_d  = wrdata_q;
        push_d    = 1'b0;
        ovf_d     = ovf_q;

        // Clear first so that a drop in the same cycle still sets the flag.
        if (cs_fall) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            SPI_IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d = SPI_SHIFT;
                end
            end
            SPI_SHIFT: begin
                // The state reflects CS from the previous cycle, so a byte
                // completing on the CS-rise cycle is still accepted.
                if (sclk_rise) begin
                    shreg_d   = shift_val;
                    bit_cnt_d = bit_cnt_q + SPI_BITCNT_W'(1);
                    if (bit_cnt_q == {SPI_BITCNT_W{1'b1}}) begin
                        if (!command_full) begin
                            push_d   = 1'b1;
                            wrdata_d = shift_val;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                if (cs_s) begin
                    state_d   = SPI_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = SPI_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign command_wrdata = wrdata_q;
    assign command_push   = push_q;
    assign frame_active   = ~cs_s;
    assign overflow       = ovf_q;

`ifdef SPI_IRQ_EN
    logic irq_n_q;

    // Registered interrupt: low while a drop is pending or the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= ~(ovf_q | command_full);
        end
    end

    assign irq_n = irq_n_q;
`else
    assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_spi_command_receiver.sv
// Directed testbench for spi_command_receiver (MSB-first and LSB-first builds).
module tb_spi_command_receiver;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk, spi_cs_n, spi_mosi, command_full;
    logic [7:0] wrdata, wrdata_l;
    logic       push, push_l, fa, fa_l, ovf, ovf_l, irq, irq_l;

    spi_command_receiver #(.SYNC_STAGES(SYNC_STAGES), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .command_full(command_full),
        .command_wrdata(wrdata), .command_push(push), .frame_active(fa),
        .overflow(ovf), .irq_n(irq)
    );

    spi_command_receiver #(.SYNC_STAGES(SYNC_STAGES), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .command_full(command_full),
        .command_wrdata(wrdata_l), .command_push(push_l), .frame_active(fa_l),
        .overflow(ovf_l), .irq_n(irq_l)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         push_cyc = 0;
    int         last_edge = 0;
    int         bb_err = 0;
    logic       prev_push = 1'b0, prev_push_l = 1'b0;
    logic [7:0] q_msb[$];
    logic [7:0] q_lsb[$];

    always @(posedge clk) cyc++;

    // Push monitor: collects bytes and flags any strobe longer than one cycle.
    always @(posedge clk) begin
        #1;
        if (push) begin
            q_msb.push_back(wrdata);
            push_cyc = cyc;
            if (prev_push) bb_err++;
        end
        if (push_l) begin
            q_lsb.push_back(wrdata_l);
            if (prev_push_l) bb_err++;
        end
        prev_push   = push;
        prev_push_l = push_l;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Sends the top nbits of b, MSB first on the wire, 4 clk per SPI phase.
    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            wait_clk(4);
            spi_clk   = 1'b1;
            last_edge = cyc;
            wait_clk(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        spi_cs_n = 1'b0;
        wait_clk(4);
        if (n > 0) spi_bits(b0, 8);
        if (n > 1) spi_bits(b1, 8);
        if (n > 2) spi_bits(b2, 8);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic clear_q();
        q_msb.delete();
        q_lsb.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        spi_clk      = 1'b0;
        spi_cs_n     = 1'b1;
        spi_mosi     = 1'b0;
        command_full = 1'b0;
        wait_clk(2);

        // Reset values
        chk("rst_wrdata", wrdata, 8'h00);
        chk("rst_push", push, 1'b0);
        chk("rst_frame_active", fa, 1'b0);
        chk("rst_overflow", ovf, 1'b0);
        chk("rst_irq_n", irq, 1'b1);
        rst_n = 1'b1;
        wait_clk(4);

        // Basic byte 0xA5 with latency measurement
        spi_cs_n = 1'b0;
        wait_clk(4);
        chk("frame_active_low_cs", fa, 1'b1);
        spi_bits(8'hA5, 8);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("basic_count", q_msb.size(), 1);
        chk("basic_data", qget(q_msb, 0), 8'hA5);
        chk("basic_lsb_data", qget(q_lsb, 0), 8'hA5);
        // Push is high during the cycle after edge +N+1, so the FIFO captures
        // it on edge +N+2 after the pin edge.
        chk("latency", 32'(push_cyc - last_edge), 32'(SYNC_STAGES + 1));
        chk("frame_active_idle", fa, 1'b0);
        chk("basic_wrdata_hold", wrdata, 8'hA5);
        clear_q();

        // Burst of three bytes in one frame
        send_frame(3, 8'h01, 8'h02, 8'h03);
        chk("burst_count", q_msb.size(), 3);
        chk("burst_b0", qget(q_msb, 0), 8'h01);
        chk("burst_b1", qget(q_msb, 1), 8'h02);
        chk("burst_b2", qget(q_msb, 2), 8'h03);
        chk("burst_lsb_b0", qget(q_lsb, 0), 8'h80);
        chk("burst_lsb_b1", qget(q_lsb, 1), 8'h40);
        chk("burst_lsb_b2", qget(q_lsb, 2), 8'hC0);
        chk("burst_overflow", ovf, 1'b0);
        clear_q();

        // Aborted byte after 5 bits, then a full 0x3C frame
        spi_cs_n = 1'b0;
        wait_clk(4);
        spi_bits(8'hFF, 5);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("abort_no_push", q_msb.size(), 0);
        send_frame(1, 8'h3C, 8'h00, 8'h00);
        chk("abort_count", q_msb.size(), 1);
        chk("abort_data", qget(q_msb, 0), 8'h3C);
        clear_q();

        // Overflow: FIFO full while 0xFF completes
        spi_cs_n = 1'b0;
        wait_clk(4);
        spi_bits(8'hFF, 7);
        spi_mosi = 1'b1;
        command_full = 1'b1;
        wait_clk(4);
        spi_clk = 1'b1;
        wait_clk(4);
        command_full = 1'b0;
        spi_clk = 1'b0;
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("ovf_no_push", q_msb.size(), 0);
        chk("ovf_set", ovf, 1'b1);
`ifdef SPI_IRQ_EN
        chk("ovf_irq_n", irq, 1'b0);
`else
        chk("ovf_irq_n", irq, 1'b1);
`endif
        spi_cs_n = 1'b0;
        wait_clk(SYNC_STAGES + 2);
        chk("ovf_clear_on_cs_fall", ovf, 1'b0);
        chk("ovf_irq_released", irq, 1'b1);
        spi_bits(8'h96, 8);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("post_ovf_data", qget(q_msb, 0), 8'h96);
        clear_q();

        // Reset in the middle of a frame
        spi_cs_n = 1'b0;
        wait_clk(4);
        spi_bits(8'hC3, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_wrdata", wrdata, 8'h00);
        chk("midrst_push", push, 1'b0);
        chk("midrst_frame_active", fa, 1'b0);
        chk("midrst_overflow", ovf, 1'b0);
        chk("midrst_irq_n", irq, 1'b1);
        spi_cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        send_frame(1, 8'h5A, 8'h00, 8'h00);
        chk("midrst_count", q_msb.size(), 1);
        chk("midrst_data", qget(q_msb, 0), 8'h5A);
        clear_q();

        // Glitch immunity: sclk toggles with CS high
        for (int i = 0; i < 8; i++) begin
            spi_mosi = i[0];
            spi_clk  = 1'b1;
            wait_clk(3);
            spi_clk  = 1'b0;
            wait_clk(3);
        end
        wait_clk(6);
        chk("glitch_no_push", q_msb.size(), 0);
        chk("glitch_bit_cnt", 32'(dut.bit_cnt_q), 0);
        chk("glitch_frame_active", fa, 1'b0);

        chk("single_cycle_pushes", bb_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
